// File: rtl/th_scan_sequencer.sv
// Initiator for the threshold-controller scan handshake: runs RepCnt scans,
// gathers BL min/max/sum plus last NW/Acc, and presents them on a valid/ready port.
module th_scan_sequencer #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned START_WIDTH = 2,
  parameter int unsigned TIMEOUT_CYC = 1048575
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Go,
  input  logic [3:0]  RepCnt,
  output logic        CLKEn,
  output logic        ScanStart,
  input  logic        ScanDone,
  input  logic [9:0]  BL,
  input  logic [3:0]  NW,
  input  logic [15:0] Acc,
  output logic        Busy,
  output logic        ResValid,
  input  logic        ResReady,
  output logic [9:0]  BLMin,
  output logic [9:0]  BLMax,
  output logic [13:0] BLSum,
  output logic [3:0]  NScans,
  output logic [3:0]  NWLast,
  output logic [15:0] AccLast,
  output logic        Timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_START, S_WAITLOW, S_WAITDONE, S_CAPTURE, S_RESULT
  } state_t;

  localparam int unsigned PMAX = (SETTLE_CYC > START_WIDTH) ? SETTLE_CYC : START_WIDTH;
  localparam int unsigned PW   = $clog2(PMAX + 1);
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] phase_cnt;
  logic [19:0]   to_cnt;
  logic [3:0]    reps;
  logic          timed_out;

  // Handshake outputs decode straight from the state register.
  assign Busy      = (state != S_IDLE);
  assign CLKEn     = (state != S_IDLE) && (state != S_RESULT);
  assign ScanStart = (state == S_START);
  assign ResValid  = (state == S_RESULT);

  always_comb begin
    state_nxt = state;
    timed_out = 1'b0;
    unique case (state)
      S_IDLE:     if (Go) state_nxt = S_SETTLE;
      S_SETTLE:   if (phase_cnt == PW'(SETTLE_CYC - 1)) state_nxt = S_START;
      S_START:    if (phase_cnt == PW'(START_WIDTH - 1)) state_nxt = S_WAITLOW;
      // A still-high ScanDone after the start pulse is stale; only a low acknowledges.
      S_WAITLOW: begin
        if (!ScanDone) begin
          state_nxt = S_WAITDONE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_RESULT;
          timed_out = 1'b1;
        end
      end
      S_WAITDONE: begin
        if (ScanDone) begin
          state_nxt = S_CAPTURE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_RESULT;
          timed_out = 1'b1;
        end
      end
      S_CAPTURE:  state_nxt = ((NScans + 4'd1) == reps) ? S_RESULT : S_START;
      S_RESULT:   if (ResReady) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      to_cnt    <= '0;
      reps      <= '0;
      BLMin     <= '0;
      BLMax     <= '0;
      BLSum     <= '0;
      NScans    <= '0;
      NWLast    <= '0;
      AccLast   <= '0;
      Timeout   <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= (state_nxt != state) ? '0 : phase_cnt + 1'b1;

      // Timeout window spans WAITLOW and WAITDONE without restarting.
      if (state == S_START)
        to_cnt <= '0;
      else if ((state == S_WAITLOW) || (state == S_WAITDONE))
        to_cnt <= to_cnt + 1'b1;

      if ((state == S_IDLE) && Go) begin
        reps    <= (RepCnt == 4'd0) ? 4'd1 : RepCnt;
        BLMin   <= '1;
        BLMax   <= '0;
        BLSum   <= '0;
        NScans  <= '0;
        Timeout <= 1'b0;
      end

      if (state == S_CAPTURE) begin
        BLMin   <= (BL < BLMin) ? BL : BLMin;
        BLMax   <= (BL > BLMax) ? BL : BLMax;
        BLSum   <= BLSum + {4'b0000, BL};
        NWLast  <= NW;
        AccLast <= Acc;
        NScans  <= NScans + 4'd1;
      end

      if (timed_out)
        Timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_th_scan_sequencer.sv
// Scoreboard bench for th_scan_sequencer: a behavioural threshold-controller model
// drives the handshake; expected run results are queued and checked on acceptance.
module tb_th_scan_sequencer;

  localparam int SETTLE = 4;
  localparam int SW     = 2;
  localparam int TO     = 100;

  typedef struct {
    int mn, mx, sum, ns, nw, acc, to, pulses;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Go = 1'b0;
  logic [3:0]  RepCnt = '0;
  logic        ScanDone = 1'b1;
  logic [9:0]  BL = '0;
  logic [3:0]  NW = '0;
  logic [15:0] Acc = '0;
  logic        ResReady = 1'b0;
  logic        CLKEn, ScanStart, Busy, ResValid, Timeout;
  logic [9:0]  BLMin, BLMax;
  logic [13:0] BLSum;
  logic [3:0]  NScans, NWLast;
  logic [15:0] AccLast;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  int   bl_tab[16];
  int   nw_tab[16];
  int   acc_tab[16];
  int   fix_lo = -1;
  int   fix_hi = -1;
  bit   rdy_always = 1'b0;
  int   last_nw = 0;
  int   last_acc = 0;
  int   pulse_cnt = 0;
  logic ss_prev = 1'b0;

  always #5 CLK = ~CLK;

  th_scan_sequencer #(
    .SETTLE_CYC (SETTLE),
    .START_WIDTH(SW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .Go(Go), .RepCnt(RepCnt),
    .CLKEn(CLKEn), .ScanStart(ScanStart), .ScanDone(ScanDone),
    .BL(BL), .NW(NW), .Acc(Acc), .Busy(Busy),
    .ResValid(ResValid), .ResReady(ResReady),
    .BLMin(BLMin), .BLMax(BLMax), .BLSum(BLSum), .NScans(NScans),
    .NWLast(NWLast), .AccLast(AccLast), .Timeout(Timeout)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result acceptor: random backpressure unless forced always-ready.
  initial forever begin
    @(posedge CLK);
    #1;
    ResReady = rdy_always ? 1'b1 : ($urandom_range(0, 2) == 0);
  end

  // Monitor: counts start pulses per run and pops the scoreboard on acceptance.
  always @(negedge CLK) begin
    exp_t e;
    if (!Busy) pulse_cnt = 0;
    else if (ScanStart && !ss_prev) pulse_cnt++;
    ss_prev = ScanStart;
    if (ResValid) begin
      check("clken_in_result", int'(CLKEn), 0);
      if (ResReady) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got ResValid, expected no pending run at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("bl_min",   int'(BLMin),   e.mn);
          check("bl_max",   int'(BLMax),   e.mx);
          check("bl_sum",   int'(BLSum),   e.sum);
          check("n_scans",  int'(NScans),  e.ns);
          check("nw_last",  int'(NWLast),  e.nw);
          check("acc_last", int'(AccLast), e.acc);
          check("timeout",  int'(Timeout), e.to);
          check("n_pulses", pulse_cnt,     e.pulses);
        end
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      bl_tab[i]  = int'($urandom_range(0, 1023));
      nw_tab[i]  = int'($urandom_range(0, 15));
      acc_tab[i] = int'($urandom_range(0, 65535));
    end
  endtask

  // One run: hang_at < 0 means all scans complete; hang_mode 1 = ScanDone never
  // returns high, 2 = ScanDone never drops, on scan index hang_at.
  task automatic run(input int rc, input int hang_at, input int hang_mode);
    int   reps, done_n, n, w, lo, hi, k;
    exp_t e;
    reps   = (rc == 0) ? 1 : rc;
    done_n = (hang_at >= 0) ? hang_at : reps;
    e.mn = 1023; e.mx = 0; e.sum = 0;
    for (int i = 0; i < done_n; i++) begin
      if (bl_tab[i] < e.mn) e.mn = bl_tab[i];
      if (bl_tab[i] > e.mx) e.mx = bl_tab[i];
      e.sum += bl_tab[i];
      last_nw  = nw_tab[i];
      last_acc = acc_tab[i];
    end
    e.ns = done_n; e.nw = last_nw; e.acc = last_acc;
    e.to = (hang_at >= 0) ? 1 : 0;
    e.pulses = (hang_at >= 0) ? hang_at + 1 : reps;
    sb.push_back(e);

    RepCnt = 4'(rc);
    Go = 1'b1;
    @(negedge CLK);
    Go = 1'b0;
    RepCnt = 4'($urandom_range(0, 15));
    n = 1;
    for (int s = 0; s < reps; s++) begin
      while (!ScanStart && n < 400) begin @(negedge CLK); n++; end
      check("scan_start_seen", int'(ScanStart), 1);
      if (s == 0) check("go_to_start_latency", n, SETTLE + 1);
      w = 0;
      while (ScanStart && w < 50) begin w++; @(negedge CLK); end
      check("start_width", w, SW);
      lo = (fix_lo >= 0) ? fix_lo : int'($urandom_range(0, 20));
      hi = (fix_hi >= 0) ? fix_hi : int'($urandom_range(1, 50));
      if (s == hang_at) begin
        k = 0;
        while (!ResValid && k < 300) begin
          if (hang_mode == 1 && k == lo) ScanDone = 1'b0;
          @(negedge CLK);
          k++;
        end
        check("timeout_latency", k, TO);
        ScanDone = 1'b1;
        break;
      end
      repeat (lo) @(negedge CLK);
      ScanDone = 1'b0;
      for (int j = 0; j < hi; j++) begin
        Go = (j == hi / 2) && ($urandom_range(0, 1) == 1);
        @(negedge CLK);
      end
      Go = 1'b0;
      BL = 10'(bl_tab[s]); NW = 4'(nw_tab[s]); Acc = 16'(acc_tab[s]);
      ScanDone = 1'b1;
      n = 0;
      if (s == reps - 1) begin
        while (!ResValid && n < 10) begin @(negedge CLK); n++; end
        check("done_to_valid", n, 2);
        if (rdy_always) begin
          Go = 1'b1;
          @(negedge CLK);
          Go = 1'b0;
          check("go_at_accept_ignored", int'(Busy), 0);
        end
      end
    end
    k = 0;
    while (Busy && k < 500) begin @(negedge CLK); k++; end
    check("return_idle", int'(Busy), 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic reset_mid();
    int n;
    RepCnt = 4'd2;
    Go = 1'b1;
    @(negedge CLK);
    Go = 1'b0;
    n = 1;
    while (!ScanStart && n < 400) begin @(negedge CLK); n++; end
    while (ScanStart && n < 400) begin @(negedge CLK); n++; end
    ScanDone = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_clken",    int'(CLKEn),     0);
    check("rst_start",    int'(ScanStart), 0);
    check("rst_busy",     int'(Busy),      0);
    check("rst_valid",    int'(ResValid),  0);
    check("rst_stats",    int'({BLMin, BLMax, BLSum, NScans}), 0);
    check("rst_last",     int'({NWLast, AccLast, Timeout}),    0);
    last_nw  = 0;
    last_acc = 0;
    ScanDone = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int rc, ha, hm;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("init_busy",  int'(Busy),     0);
    check("init_clken", int'(CLKEn),    0);
    check("init_valid", int'(ResValid), 0);
    check("init_stats", int'({BLMin, BLMax, BLSum, NScans, Timeout}), 0);
    repeat (2) @(negedge CLK);

    // Single scan with fixed values
    fill_rand();
    bl_tab[0] = 'h155; nw_tab[0] = 5; acc_tab[0] = 'h1234;
    fix_lo = 3; fix_hi = 50;
    run(1, -1, 0);

    // Repeat statistics
    fill_rand();
    bl_tab[0] = 100; bl_tab[1] = 300; bl_tab[2] = 200; bl_tab[3] = 1023;
    fix_lo = -1; fix_hi = -1;
    run(4, -1, 0);

    fill_rand();
    run(0, -1, 0);

    fill_rand();
    for (int i = 0; i < 16; i++) bl_tab[i] = 1023;
    run(15, -1, 0);

    // Timeouts: no return on scan 2, and a controller that never acknowledges
    fill_rand();
    run(3, 1, 1);
    fill_rand();
    run(2, 0, 2);

    // Stale done held through START, acknowledged 10 cycles later
    fill_rand();
    fix_lo = 10; fix_hi = 20;
    run(2, -1, 0);
    fix_lo = -1; fix_hi = -1;

    reset_mid();
    fill_rand();
    run(2, -1, 0);

    rdy_always = 1'b1;
    fill_rand();
    run(3, -1, 0);
    rdy_always = 1'b0;

    for (int r = 0; r < 12; r++) begin
      fill_rand();
      rc = int'($urandom_range(0, 6));
      ha = -1;
      hm = 0;
      if ($urandom_range(0, 3) == 0) begin
        ha = int'($urandom_range(0, ((rc == 0) ? 1 : rc) - 1));
        hm = int'($urandom_range(1, 2));
      end
      run(rc, ha, hm);
    end

    repeat (5) @(negedge CLK);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_results: got %0d unconsumed, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
